// File: rtl/memory_access_unit.sv
// memory_access_unit: LSU bus initiator for a word-wide tri-state memory.
// Extends sub-word loads and performs read-modify-write for sub-word stores.
module memory_access_unit #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  tri   [31:0]           mem_data,
  output logic                  mem_re,
  output logic                  mem_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RMW_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [1:0]            r_off;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [31:0]           r_wdata;
  logic [31:0]           r_wword;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_rdata;
  logic                  r_resp_error;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_re;
  logic                  r_mem_we;

  logic                  w_accept;
  logic                  w_bad;
  logic                  w_ld;
  logic                  w_sw;
  logic                  w_ss;
  logic [4:0]            w_shamt;
  logic [31:0]           w_lane;
  logic [31:0]           w_load;
  logic [31:0]           w_mask;
  logic [31:0]           w_merge;

  assign w_accept = req_valid && r_req_ready;
  assign w_bad = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign w_ld = !w_bad && !req_we;
  assign w_sw = !w_bad && req_we && req_size == 2'b10;
  assign w_ss = !w_bad && req_we && req_size != 2'b10;

  // Lane offset in bits; little-endian byte k lives at bits 8k+7:8k
  assign w_shamt = {r_off, 3'b000};
  assign w_lane  = mem_data >> w_shamt;

  always_comb begin
    w_load = mem_data;
    unique case (r_size)
      2'b00: w_load = r_uns ? {24'b0, w_lane[7:0]}
                            : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01: w_load = r_uns ? {16'b0, w_lane[15:0]}
                            : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load = mem_data;
    endcase
  end

  assign w_mask  = (r_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF)
                << w_shamt;
  assign w_merge = (mem_data & ~w_mask)
                 | ((r_wdata << w_shamt) & w_mask);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_off        <= 2'b00;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_wdata      <= 32'b0;
      r_wword      <= 32'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'b0;
      r_resp_error <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_off       <= req_addr[1:0];
            r_size      <= req_size;
            r_uns       <= req_unsigned;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            unique case (1'b1)
              w_bad: begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
                r_resp_error <= 1'b1;
                r_resp_rdata <= 32'b0;
              end
              w_ld: begin
                r_state  <= S_READ;
                r_mem_re <= 1'b1;
              end
              w_sw: begin
                r_state  <= S_WRITE;
                r_wword  <= req_wdata;
                r_mem_we <= 1'b1;
              end
              w_ss: begin
                r_state  <= S_RMW_READ;
                r_mem_re <= 1'b1;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_READ: begin
          r_mem_re     <= 1'b0;
          r_resp_rdata <= w_load;
          r_resp_error <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RMW_READ: begin
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b1;
          r_wword  <= w_merge;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_mem_we     <= 1'b0;
          r_resp_rdata <= 32'b0;
          r_resp_error <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;
  assign mem_addr   = r_mem_addr;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;
  assign mem_data   = r_mem_we ? r_wword : 32'bz;

endmodule
